// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver (filtered clock, frame FSM) feeding a FWFT scan-code FIFO
// Optional error counter enabled by macro PS2_RX_ERR_COUNT_EN.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic [7:0]                    err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, fall_stb;
    logic [FW-1:0] filt_cnt;

    state_t        state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [9:0]    shreg, shreg_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          push, perr, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, wr_en, drop;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_i;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the new level is adopted only after it persisted FILTER_LEN cycles.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall_stb <= 1'b0;
        end else begin
            fall_stb <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall_stb <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            to_cnt  <= to_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        to_cnt_n  = to_cnt;
        push      = 1'b0;
        perr      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (fall_stb && !dat_s2) begin
                    state_n   = SHIFT;
                    bit_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (fall_stb) begin
                    shreg_n  = {dat_s2, shreg[9:1]};
                    to_cnt_n = '0;
                    if (bit_cnt == 4'd9) state_n = CHECK;
                    else bit_cnt_n = bit_cnt + 1'b1;
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    ferr    = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            CHECK: begin
                state_n = IDLE;
                if (!(^shreg[8:0])) perr = 1'b1;
                else if (!shreg[9]) ferr = 1'b1;
                else push = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= perr;
            frame_err  <= ferr;
        end
    end

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign rx_valid = (count != '0);
    assign pop      = rx_valid & rx_ready;
    // When full, a simultaneous pop frees the slot being written this same edge.
    assign wr_en    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_level = count;

    always_ff @(posedge ACLK) begin
        if (wr_en) mem[wr_ptr] <= shreg[7:0];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (err_clr) overflow <= 1'b0;
    end

`ifdef PS2_RX_ERR_COUNT_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_count <= 8'h00;
        end else if (err_clr) begin
            err_count <= {7'h00, parity_err | frame_err};
        end else if ((parity_err | frame_err) && err_count != 8'hFF) begin
            err_count <= err_count + 8'h01;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int FL    = 8;
    localparam int TO    = 400;
    localparam int HALF  = 20;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       err_clr = 1'b0;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int perr_seen = 0;
    int ferr_seen = 0;
    int exp_err = 0;
    logic [7:0] exp_q[$];

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
        .overflow(overflow), .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (parity_err) perr_seen++;
        if (frame_err)  ferr_seen++;
    end

    function automatic logic [7:0] exp_cnt(input int e);
`ifdef PS2_RX_ERR_COUNT_EN
        return (e > 255) ? 8'hFF : 8'(e);
`else
        return 8'h00;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // nbits < 11 sends a truncated frame; lat checks rx_valid timing after the stop-bit fall.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop,
                              input int nbits, input bit lat, input bit glitch);
        logic [10:0] bits;
        bits = {stop, (~^d) ^ par_bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge ACLK);
            ps2_data_i = bits[i];
            if (glitch && i == 4) begin
                idle(5);
                ps2_clk_i = 1'b0;
                idle(FL - 2);
                ps2_clk_i = 1'b1;
                idle(HALF - 5 - FL + 2);
            end else begin
                idle(HALF);
            end
            ps2_clk_i = 1'b0;
            if (lat && i == 10) begin
                repeat (FL + 3) @(posedge ACLK);
                @(negedge ACLK);
                n_tests++;
                if (rx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early: rx_valid=%b required 0", rx_valid);
                end
                @(negedge ACLK);
                n_tests++;
                if (rx_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency_rise: rx_valid=%b required 1", rx_valid);
                end
                idle(HALF - 2 - FL - 3);
            end else begin
                idle(HALF);
            end
            ps2_clk_i = 1'b1;
        end
        idle(30);
    endtask

    task automatic send_good(input logic [7:0] d, input bit lat, input bit glitch);
        send_frame(d, 1'b0, 1'b1, 11, lat, glitch);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic drain(input string name, input int n);
        logic [7:0] e;
        int waited;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!rx_valid && waited < 200) begin
                @(negedge ACLK);
                waited++;
            end
            n_tests++;
            if (!rx_valid) begin
                n_fail++;
                $display("FAIL %s_wait: rx_valid=0 required 1 (entry %0d)", name, k);
                return;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            if (rx_data !== e) begin
                n_fail++;
                $display("FAIL %s_data: rx_data=%h required %h", name, rx_data, e);
            end
            rx_ready = 1'b1;
            @(negedge ACLK);
            rx_ready = 1'b0;
        end
        n_tests++;
        if (rx_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_empty: valid=%b level=%0d required 0/0", name, rx_valid, fifo_level);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_level !== 4'd0 || overflow !== 1'b0 ||
            parity_err !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%h level=%0d ovf=%b perr=%b ferr=%b cnt=%0d required all zero",
                     name, rx_valid, rx_data, fifo_level, overflow, parity_err, frame_err, err_count);
        end
    endtask

    task automatic test_reset();
        idle(3);
        check_reset_outputs("reset_state");
        ARESETN = 1'b1;
        idle(20);
    endtask

    task automatic test_basic();
        send_good(8'h1C, 1'b1, 1'b0);
        n_tests++;
        if (fifo_level !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_level: level=%0d required 1", fifo_level);
        end
        drain("basic", 1);
    endtask

    task automatic test_parity();
        int p0, f0;
        p0 = perr_seen;
        f0 = ferr_seen;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        exp_err++;
        n_tests++;
        if (perr_seen !== p0 + 1 || ferr_seen !== f0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_pulse: perr=%0d ferr=%0d valid=%b required %0d/%0d/0",
                     perr_seen - p0, ferr_seen - f0, rx_valid, 1, 0);
        end
        n_tests++;
        if (err_count !== exp_cnt(exp_err)) begin
            n_fail++;
            $display("FAIL parity_count: err_count=%0d required %0d", err_count, exp_cnt(exp_err));
        end
    endtask

    task automatic test_bad_stop();
        int p0, f0;
        p0 = perr_seen;
        f0 = ferr_seen;
        send_frame(8'hA5, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        exp_err++;
        n_tests++;
        if (ferr_seen !== f0 + 1 || perr_seen !== p0 || rx_valid !== 1'b0 ||
            err_count !== exp_cnt(exp_err)) begin
            n_fail++;
            $display("FAIL bad_stop: ferr=%0d perr=%0d valid=%b cnt=%0d required 1/0/0/%0d",
                     ferr_seen - f0, perr_seen - p0, rx_valid, err_count, exp_cnt(exp_err));
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_good(8'(i), 1'b0, 1'b0);
        n_tests++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: level=%0d ovf=%b required 8/1", fifo_level, overflow);
        end
        drain("ovf", 8);
        @(negedge ACLK);
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
        exp_err = 0;
        n_tests++;
        if (overflow !== 1'b0 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL err_clr: ovf=%b cnt=%0d required 0/0", overflow, err_count);
        end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = ferr_seen;
        send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        idle(TO + 50);
        exp_err++;
        n_tests++;
        if (ferr_seen !== f0 + 1 || rx_valid !== 1'b0 || err_count !== exp_cnt(exp_err)) begin
            n_fail++;
            $display("FAIL timeout: ferr=%0d valid=%b cnt=%0d required 1/0/%0d",
                     ferr_seen - f0, rx_valid, err_count, exp_cnt(exp_err));
        end
        send_good(8'hF0, 1'b0, 1'b0);
        drain("after_timeout", 1);
    endtask

    task automatic test_glitch();
        int p0, f0;
        p0 = perr_seen;
        f0 = ferr_seen;
        send_good(8'h5A, 1'b0, 1'b1);
        n_tests++;
        if (perr_seen !== p0 || ferr_seen !== f0) begin
            n_fail++;
            $display("FAIL glitch_err: perr=%0d ferr=%0d required 0/0", perr_seen - p0, ferr_seen - f0);
        end
        drain("glitch", 1);
    endtask

    task automatic test_midframe_reset();
        send_good(8'h33, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 6, 1'b0, 1'b0);
        @(negedge ACLK);
        ARESETN = 1'b0;
        exp_q.delete();
        exp_err = 0;
        idle(2);
        check_reset_outputs("midframe_reset");
        ARESETN = 1'b1;
        idle(20);
        send_good(8'h29, 1'b0, 1'b0);
        drain("post_reset", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_bad_stop();
        test_overflow();
        test_timeout();
        test_glitch();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2..64.
REQ-002 Parameter: FILTER_LEN, 8, ACLK cycles a synchronized ps2_clk level must hold before it is accepted.
REQ-003 Parameter: TIMEOUT_CYCLES, 100000, ACLK cycles without a filtered falling edge before a partial frame is abandoned.
REQ-004 Port: ACLK  in  1  single clock for the whole block.
REQ-005 Port: ARESETN  in  1  reset, asynchronous and active-low.
REQ-006 Port: ps2_clk_i  in  1  raw PS/2 clock from the pad, asynchronous.
REQ-007 Port: ps2_data_i  in  1  raw PS/2 data from the pad, asynchronous.
REQ-008 Port: rx_data  out  8  FIFO head byte, first-word-fall-through.
REQ-009 Port: rx_valid  out  1  FIFO not empty.
REQ-010 Port: rx_ready  in  1  consumer (AXI register block) pops the head byte.
REQ-011 Port: fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 Port: overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-013 Port: err_clr  in  1  one-cycle pulse that clears overflow and err_count.
REQ-014 Port: parity_err  out  1  one-cycle pulse on a parity failure.
REQ-015 Port: frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-016 Port: err_count  out  8  count of parity and frame errors.

Function
REQ-017 ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchronizer.
REQ-018 The filtered clock SHALL change level only after the synchronized ps2_clk has differed from it for FILTER_LEN consecutive cycles.
REQ-019 A filtered 1->0 transition SHALL produce a one-cycle edge strobe, which samples synchronized data.
REQ-020 FSM states SHALL be IDLE, SHIFT and CHECK.
REQ-021 IDLE: on an edge with data=0 (start bit), go to SHIFT with bit_cnt=0; an edge with data=1 SHALL be ignored.
REQ-022 SHIFT: each edge shifts in one bit, LSB first, as 8 data bits, then parity, then stop; the 10th edge SHALL move to CHECK.
REQ-023 CHECK lasts one cycle: if odd parity holds over data+parity and stop=1, push the byte; otherwise pulse parity_err (parity takes precedence) or frame_err; then return to IDLE.
REQ-024 In SHIFT, TIMEOUT_CYCLES cycles with no edge SHALL return the FSM to IDLE, pulse frame_err and push nothing.
REQ-025 Latency: rx_valid SHALL rise 2 ACLK cycles after the stop-bit edge strobe when the FIFO was empty.
REQ-026 A pop occurs on any cycle with rx_valid&rx_ready; rx_ready while empty SHALL have no effect.
REQ-027 A push while full, with no pop in the same cycle, SHALL drop the byte, set overflow and leave the FIFO contents unchanged.
REQ-028 A push and a pop in the same cycle SHALL both take effect, level unchanged, including when full.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.
REQ-030 err_clr SHALL clear overflow and err_count on the next edge; an overflow or error in the same cycle SHALL win (flag set, count=1).

Reset
REQ-031 ARESETN low SHALL asynchronously force: FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0, fifo_level=0, overflow=0, parity_err=0, frame_err=0, err_count=0, filtered clock=1, synchronizers=1.
REQ-032 Reset in mid-frame SHALL discard the partial frame; the first full frame after release SHALL be received correctly.

Configuration
REQ-033 Macro PS2_RX_ERR_COUNT_EN defined: err_count increments on each parity_err or frame_err pulse and saturates at 255.
REQ-034 Macro PS2_RX_ERR_COUNT_EN undefined: no counter logic is present, err_count is tied to 0, and the error pulses still operate.

Verification
REQ-035 Frame 0x1C with parity 0 and stop 1 -> rx_valid after 2 cycles, rx_data=0x1C, fifo_level=1; pop -> level 0.
REQ-036 Frame 0x1C with parity 1 -> parity_err pulses once, no push, err_count=1 (macro on) or 0 (macro off).
REQ-037 Nine frames 0x01..0x09 with rx_ready=0 -> level=8, overflow=1, and the pop sequence is 0x01..0x08; err_clr -> overflow=0.
REQ-038 Start bit plus 4 bits, then idle for TIMEOUT_CYCLES -> frame_err pulse; the next frame 0xF0 is received intact.
REQ-039 A ps2_clk low glitch of FILTER_LEN-2 cycles during a frame 0x5A -> no extra bit is sampled, and rx_data=0x5A.
REQ-040 ARESETN asserted after 6 bits of a frame, then 0x29 sent -> all outputs are at reset values during reset, and rx_data=0x29 afterwards.
